mac_rx_parser: RTL and testbench

MAC_RX_PARSER -- requirements
Module: mac_rx_parser

---
 rtl/eth_pkg.sv | 48 ++++
 rtl/crc32_d8.sv | 30 +++
 rtl/mac_rx_parser.sv | 191 +++++++++++++++++++
 tb/tb_mac_rx_parser.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet receive definitions: parser states, framing bytes,
// CRC-32 constants and the per-byte CRC update.
package eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_BODY     = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
  localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

  // Reflected CRC-32, data bits consumed LSB first.
  function automatic logic [31:0] crc32_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Byte j of an address as it appears on the wire (byte 0 = MSB).
  function automatic logic [7:0] mac_byte(
    input logic [47:0] mac,
    input logic [2:0]  j
  );
    case (j)
      3'd0:    mac_byte = mac[47:40];
      3'd1:    mac_byte = mac[39:32];
      3'd2:    mac_byte = mac[31:24];
      3'd3:    mac_byte = mac[23:16];
      3'd4:    mac_byte = mac[15:8];
      default: mac_byte = mac[7:0];
    endcase
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// One-byte-per-cycle Ethernet CRC-32 register with synchronous clear
// and enable.
module crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr)     crc_d = CRC_INIT;
    else if (en) crc_d = crc32_byte(crc_q, data);
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= CRC_INIT;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/mac_rx_parser.sv
// GMII receive parser: strips preamble/SFD, filters destination,
// checks FCS and length, streams dst..payload with a bad-frame flag.
module mac_rx_parser
  import eth_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h00D0_0800_0002,
  parameter int          MIN_FRAME = 64,
  parameter int          MAX_FRAME = 1518
) (
  input  logic        rx_clk_in,
  input  logic        rx_rst_in,
  input  logic [7:0]  gmii_rxd_in,
  input  logic        gmii_rx_dv_in,
  input  logic        gmii_rx_er_in,
  output logic [7:0]  m_axis_tdata_out,
  output logic        m_axis_tvalid_out,
  output logic        m_axis_tlast_out,
  output logic        m_axis_tuser_out,
  output logic [15:0] frame_ok_cnt_out,
  output logic [15:0] frame_err_cnt_out
);

  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME);
  // Oversize frames are cut so that the final beat is beat MAX_FRAME.
  localparam logic [15:0] CUT_IDX = 16'(MAX_FRAME + 4);

  rx_state_e   state_q, state_d;
  logic [39:0] dly_q, dly_d;
  logic [15:0] cnt_q, cnt_d;
  logic        er_q, er_d;
  logic        uc_q, uc_d;
  logic        bc_q, bc_d;
  logic        ign_q, ign_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        tuser_q, tuser_d;
  logic [15:0] ok_cnt_q, ok_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic        crc_clr;
  logic        crc_en;
  logic [31:0] crc;

  crc32_d8 u_crc (
    .clk  (rx_clk_in),
    .rst  (rx_rst_in),
    .clr  (crc_clr),
    .en   (crc_en),
    .data (gmii_rxd_in),
    .crc  (crc)
  );

  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    cnt_d    = cnt_q;
    er_d     = er_q;
    uc_d     = uc_q;
    bc_d     = bc_q;
    ign_d    = ign_q;
    tdata_d  = 8'h00;
    tvalid_d = 1'b0;
    tlast_d  = 1'b0;
    tuser_d  = 1'b0;
    crc_clr  = 1'b0;
    crc_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // After reset, wait out any frame already in flight.
        if (!gmii_rx_dv_in) begin
          ign_d = 1'b0;
        end else if (!ign_q) begin
          if (gmii_rxd_in == PREAMBLE_BYTE) state_d = ST_PREAMBLE;
          else                              state_d = ST_DROP;
        end
      end

      ST_PREAMBLE: begin
        if (!gmii_rx_dv_in) begin
          state_d = ST_IDLE;
        end else if (gmii_rxd_in == SFD_BYTE) begin
          state_d = ST_BODY;
          dly_d   = '0;
          cnt_d   = '0;
          er_d    = 1'b0;
          uc_d    = 1'b1;
          bc_d    = 1'b1;
          crc_clr = 1'b1;
        end else if (gmii_rxd_in != PREAMBLE_BYTE) begin
          state_d = ST_DROP;
        end
      end

      ST_BODY: begin
        if (!gmii_rx_dv_in) begin
          state_d = ST_IDLE;
          if (cnt_q >= 16'd6) begin
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
            tdata_d  = dly_q[39:32];
            tuser_d  = er_q
                     | (crc != CRC_RESIDUE)
                     | (cnt_q < MIN_LEN);
          end
        end else begin
          crc_en = 1'b1;
          dly_d  = {dly_q[31:0], gmii_rxd_in};
          cnt_d  = cnt_q + 16'd1;
          er_d   = er_q | gmii_rx_er_in;
          if (cnt_q < 16'd6) begin
            uc_d = uc_q & (gmii_rxd_in
                 == mac_byte(LOCAL_MAC, cnt_q[2:0]));
            bc_d = bc_q & (gmii_rxd_in
                 == mac_byte(BCAST_MAC, cnt_q[2:0]));
          end
          if (!(uc_d | bc_d)) begin
            state_d = ST_DROP;
          end else if (cnt_q >= 16'd5) begin
            tvalid_d = 1'b1;
            tdata_d  = dly_q[39:32];
            if (cnt_q == CUT_IDX) begin
              tlast_d = 1'b1;
              tuser_d = 1'b1;
              state_d = ST_DROP;
            end
          end
        end
      end

      ST_DROP: begin
        if (!gmii_rx_dv_in) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ok_cnt_d  = ok_cnt_q;
    err_cnt_d = err_cnt_q;
    if (tlast_d) begin
      if (tuser_d) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      end else begin
        if (ok_cnt_q != 16'hFFFF) ok_cnt_d = ok_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge rx_clk_in) begin
    if (rx_rst_in) begin
      state_q   <= ST_IDLE;
      dly_q     <= '0;
      cnt_q     <= '0;
      er_q      <= 1'b0;
      uc_q      <= 1'b0;
      bc_q      <= 1'b0;
      ign_q     <= 1'b1;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tuser_q   <= 1'b0;
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      cnt_q     <= cnt_d;
      er_q      <= er_d;
      uc_q      <= uc_d;
      bc_q      <= bc_d;
      ign_q     <= ign_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tuser_q   <= tuser_d;
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign m_axis_tdata_out  = tdata_q;
  assign m_axis_tvalid_out = tvalid_q;
  assign m_axis_tlast_out  = tlast_q;
  assign m_axis_tuser_out  = tuser_q;
  assign frame_ok_cnt_out  = ok_cnt_q;
  assign frame_err_cnt_out = err_cnt_q;

endmodule

// File: tb/tb_mac_rx_parser.sv
// Scoreboard bench for mac_rx_parser: directed frames push expected
// beats; a negedge monitor pops and compares every output beat.
module tb_mac_rx_parser;

  typedef logic [7:0] bq_t[$];

  localparam logic [47:0] LMAC  = 48'h00D0_0800_0002;
  localparam logic [47:0] OMAC  = 48'h00D0_0800_0003;
  localparam logic [47:0] BMAC  = 48'hFFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rxd = 8'h00;
  logic        dv  = 1'b0;
  logic        er  = 1'b0;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tlast;
  logic        tuser;
  logic [15:0] ok_cnt;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;
  int exp_ok = 0;
  int exp_err = 0;
  logic [9:0] exp_q[$];

  always #4 clk = ~clk;

  mac_rx_parser dut (
    .rx_clk_in         (clk),
    .rx_rst_in         (rst),
    .gmii_rxd_in       (rxd),
    .gmii_rx_dv_in     (dv),
    .gmii_rx_er_in     (er),
    .m_axis_tdata_out  (tdata),
    .m_axis_tvalid_out (tvalid),
    .m_axis_tlast_out  (tlast),
    .m_axis_tuser_out  (tuser),
    .frame_ok_cnt_out  (ok_cnt),
    .frame_err_cnt_out (err_cnt)
  );

  // Monitor: every valid beat must match the head of the queue.
  always @(negedge clk) begin
    logic [9:0] e;
    if (tvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat: unexpected data=%h last=%b user=%b",
                 tdata, tlast, tuser);
      end else begin
        e = exp_q.pop_front();
        if ({tdata, tlast} != e[9:1] || (e[1] && tuser != e[0])) begin
          errors++;
          $display("FAIL beat: got data=%h last=%b user=%b want %h %b %b",
                   tdata, tlast, tuser, e[9:2], e[1], e[0]);
        end
      end
    end else if (tdata != 8'h00 || tlast || tuser) begin
      checks++;
      errors++;
      $display("FAIL idle: got data=%h last=%b user=%b want zeros",
               tdata, tlast, tuser);
    end
  end

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  function automatic logic [31:0] fcs_of(input bq_t f);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (f[i]) begin
      c = c ^ {24'h0, f[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t mk(input logic [47:0] dst, input int n,
                             input int seed);
    bq_t f;
    logic [31:0] c;
    logic [47:0] src;
    src = 48'h0200_0000_0001;
    for (int i = 0; i < 6; i++) f.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) f.push_back(src[47-8*i -: 8]);
    f.push_back(8'h08);
    f.push_back(8'h00);
    for (int i = 14; i < n - 4; i++) f.push_back(8'((i * 7 + seed) & 255));
    c = fcs_of(f);
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    return f;
  endfunction

  task automatic expect_beats(input bq_t f, input int n,
                              input logic last, input logic user);
    for (int i = 0; i < n; i++)
      exp_q.push_back({f[i], last && (i == n - 1), user && (i == n - 1)});
    if (last) begin
      if (user) exp_err++;
      else      exp_ok++;
    end
  endtask

  task automatic drive(input logic [7:0] b, input logic e, input logic r);
    @(posedge clk);
    #1;
    rxd = b;
    dv  = 1'b1;
    er  = e;
    rst = r;
  endtask

  task automatic send(input bq_t f, input int er_at, input int gap,
                      input int rst_at);
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b0, 1'b0);
    drive(8'hD5, 1'b0, 1'b0);
    for (int i = 0; i < f.size(); i++)
      drive(f[i], i == er_at, i == rst_at);
    @(posedge clk);
    #1;
    dv  = 1'b0;
    rxd = 8'h00;
    er  = 1'b0;
    rst = 1'b0;
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic settle(input string name);
    repeat (12) @(posedge clk);
    #1;
    chk({name, " drain"}, exp_q.size(), 0);
    chk({name, " ok_cnt"}, int'(ok_cnt), exp_ok);
    chk({name, " err_cnt"}, int'(err_cnt), exp_err);
  endtask

  initial begin
    bq_t f;
    bq_t g;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset tvalid", int'(tvalid), 0);
    chk("reset tlast", int'(tlast), 0);
    chk("reset tdata", int'(tdata), 0);
    chk("reset ok_cnt", int'(ok_cnt), 0);
    chk("reset err_cnt", int'(err_cnt), 0);
    repeat (2) @(posedge clk);

    f = mk(LMAC, 64, 1);
    expect_beats(f, 60, 1'b1, 1'b0);
    send(f, -1, 12, -1);
    settle("good64");

    f[20] = f[20] ^ 8'h10;
    expect_beats(f, 60, 1'b1, 1'b1);
    send(f, -1, 12, -1);
    settle("badcrc");

    f = mk(OMAC, 64, 2);
    send(f, -1, 12, -1);
    settle("otherdst");

    f = mk(BMAC, 64, 3);
    expect_beats(f, 60, 1'b1, 1'b0);
    send(f, -1, 12, -1);
    settle("bcast");

    g = {};
    for (int i = 0; i < 5; i++) g.push_back(LMAC[47-8*i -: 8]);
    send(g, -1, 12, -1);
    settle("short5");

    f = mk(LMAC, 40, 4);
    expect_beats(f, 36, 1'b1, 1'b1);
    send(f, -1, 12, -1);
    settle("runt40");

    f = mk(LMAC, 1600, 5);
    expect_beats(f, 1518, 1'b1, 1'b1);
    send(f, -1, 12, -1);
    settle("long1600");

    f = mk(LMAC, 72, 6);
    expect_beats(f, 68, 1'b1, 1'b1);
    send(f, 20, 12, -1);
    settle("rxer72");

    f = mk(LMAC, 64, 7);
    g = mk(BMAC, 64, 8);
    expect_beats(f, 60, 1'b1, 1'b0);
    expect_beats(g, 60, 1'b1, 1'b0);
    send(f, -1, 1, -1);
    send(g, -1, 12, -1);
    settle("b2b");

    // Reset lands on body byte 30: bytes 0..24 were already streamed.
    f = mk(LMAC, 64, 9);
    expect_beats(f, 25, 1'b0, 1'b0);
    exp_ok  = 0;
    exp_err = 0;
    send(f, -1, 12, 30);
    settle("rstmid");

    f = mk(LMAC, 64, 10);
    expect_beats(f, 60, 1'b1, 1'b0);
    send(f, -1, 12, -1);
    settle("afterrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
